fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 139 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among NUM_REQ producers.
// Define ARB_FIXED_PRIORITY_EN to replace round-robin with lowest-index-first selection.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BCW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t         state, state_n;
    logic [IDW-1:0] rr_ptr, rr_ptr_n;
    logic [IDW-1:0] grant_id_n;
    logic [BCW-1:0] beat_cnt, beat_cnt_n;
    logic           stall_q;
    logic           wr_ok;

`ifdef ARB_FIXED_PRIORITY_EN
    function automatic logic [IDW-1:0] pick_req(input logic [NUM_REQ-1:0] v);
        logic [IDW-1:0] sel;
        logic           found;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && v[k]) begin
                sel   = IDW'(k);
                found = 1'b1;
            end
        end
        return sel;
    endfunction
`else
    // First valid producer scanning ptr, ptr+1, ... wrapping at NUM_REQ.
    function automatic logic [IDW-1:0] pick_req(input logic [NUM_REQ-1:0] v,
                                                 input logic [IDW-1:0]     ptr);
        logic [IDW-1:0] sel;
        logic           found;
        int             idx;
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && v[idx]) begin
                sel   = IDW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction
`endif

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (id == IDW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
            stall_q  <= 1'b0;
        end else begin
            state    <= state_n;
            rr_ptr   <= rr_ptr_n;
            grant_id <= grant_id_n;
            beat_cnt <= beat_cnt_n;
            // fifo_full rises one cycle after the slot-filling write; cover that gap.
            stall_q  <= fifo_wr_en && fifo_almost_full;
        end
    end

    always_comb begin
        state_n      = state;
        rr_ptr_n     = rr_ptr;
        grant_id_n   = grant_id;
        beat_cnt_n   = beat_cnt;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_data_in = '0;
        wr_ok        = !fifo_full && !stall_q;

        case (state)
            IDLE: begin
                if (|req_valid) begin
`ifdef ARB_FIXED_PRIORITY_EN
                    grant_id_n = pick_req(req_valid);
`else
                    grant_id_n = pick_req(req_valid, rr_ptr);
`endif
                    beat_cnt_n = '0;
                    state_n    = BURST;
                end
            end
            BURST: begin
                req_ready[grant_id] = wr_ok;
                if (!req_valid[grant_id]) begin
                    state_n = IDLE;
`ifndef ARB_FIXED_PRIORITY_EN
                    rr_ptr_n = next_id(grant_id);
`endif
                end else if (wr_ok) begin
                    fifo_wr_en   = 1'b1;
                    fifo_data_in = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
                    beat_cnt_n   = beat_cnt + 1'b1;
                    if (beat_cnt == BCW'(MAX_BURST - 1)) begin
                        state_n = IDLE;
`ifndef ARB_FIXED_PRIORITY_EN
                        rr_ptr_n = next_id(grant_id);
`endif
                    end
                end
                // A stalled FIFO with valid held simply waits here; beat_cnt holds.
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=4).
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int MB = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NR-1:0]      req_valid = '0;
    logic [NR*DW-1:0]   req_data;
    logic [NR-1:0]      req_ready;
    logic               fifo_wr_en;
    logic [DW-1:0]      fifo_data_in;
    logic               fifo_full;
    logic               fifo_almost_full;
    logic [1:0]         grant_id;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Depth-16 FIFO flag model: almost_full follows the count, full lags it by a cycle.
    logic       fifo_model_en = 1'b0;
    logic       fifo_init = 1'b0;
    logic [4:0] fcount = '0;
    logic       full_q = 1'b0;
    logic       ovf = 1'b0;
    int         n_writes = 0;

    assign fifo_full        = fifo_model_en && full_q;
    assign fifo_almost_full = fifo_model_en && (fcount == 5'd15);

    always @(posedge clk) begin
        if (fifo_init) begin
            fcount   <= 5'd15;
            full_q   <= 1'b0;
            ovf      <= 1'b0;
            n_writes <= 0;
        end else begin
            full_q <= (fcount == 5'd16);
            if (fifo_wr_en) begin
                n_writes <= n_writes + 1;
                if (fcount == 5'd16) ovf <= 1'b1;
                else fcount <= fcount + 5'd1;
            end
        end
    end

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_ready        (req_ready),
        .fifo_wr_en       (fifo_wr_en),
        .fifo_data_in     (fifo_data_in),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .grant_id         (grant_id),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dat(input int i);
        return 32'hD000_0000 | (i * 32'h0000_1111);
    endfunction

    // Packs {req_ready, fifo_wr_en, busy, grant_id} for one compact comparison.
    function automatic logic [7:0] ctl(input logic [3:0] rdy, input logic we,
                                       input logic bz, input logic [1:0] g);
        return {rdy, we, bz, g};
    endfunction

    function automatic logic [7:0] obs();
        return {req_ready, fifo_wr_en, busy, grant_id};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = '0;
        fifo_init = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        fifo_init = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            n_tests++;
            if (obs() !== 8'h00) begin
                n_fail++;
                $display("FAIL reset c=%0d ctl got %h exp 00", c, obs());
            end
            n_tests++;
            if (fifo_data_in !== '0) begin
                n_fail++;
                $display("FAIL reset_data c=%0d got %h exp 0", c, fifo_data_in);
            end
        end
    endtask

    task automatic test_round_robin();
        int            gorder[5] = '{0, 1, 2, 3, 0};
        int            g;
        logic [7:0]    exp_c;
        logic [DW-1:0] exp_d;
        logic [3:0]    oh;
        do_reset();
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            req_valid = 4'hF;
            #1;
            g = gorder[c / 5];
            if (c % 5 == 0) begin
                exp_c = ctl(4'b0, 1'b0, 1'b0, (c == 0) ? 2'd0 : 2'(gorder[c / 5 - 1]));
                exp_d = '0;
            end else begin
                oh    = 4'b0001 << g;
                exp_c = ctl(oh, 1'b1, 1'b1, 2'(g));
                exp_d = dat(g);
            end
            n_tests++;
            if (obs() !== exp_c) begin
                n_fail++;
                $display("FAIL rr_ctl c=%0d got %h exp %h", c, obs(), exp_c);
            end
            n_tests++;
            if (fifo_data_in !== exp_d) begin
                n_fail++;
                $display("FAIL rr_data c=%0d got %h exp %h", c, fifo_data_in, exp_d);
            end
        end
        @(negedge clk);
        req_valid = '0;
        n_tests++;
        if (n_writes != 20) begin
            n_fail++;
            $display("FAIL rr_beats got %0d exp 20", n_writes);
        end
    endtask

    task automatic test_drop();
        logic [7:0]    exp_c[6] = '{8'h00, 8'h4E, 8'h4E, 8'h46, 8'h02, 8'h2D};
        logic [3:0]    vin[6]   = '{4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0010};
        logic [DW-1:0] exp_d;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            req_valid = vin[c];
            #1;
            exp_d = (c == 1 || c == 2) ? dat(2) : (c == 5) ? dat(1) : '0;
            n_tests++;
            if (obs() !== exp_c[c]) begin
                n_fail++;
                $display("FAIL drop_ctl c=%0d got %h exp %h", c, obs(), exp_c[c]);
            end
            n_tests++;
            if (fifo_data_in !== exp_d) begin
                n_fail++;
                $display("FAIL drop_data c=%0d got %h exp %h", c, fifo_data_in, exp_d);
            end
            if (c == 4) begin
                n_tests++;
                if (n_writes != 2) begin
                    n_fail++;
                    $display("FAIL drop_beats got %0d exp 2", n_writes);
                end
            end
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_stall();
        logic [7:0] exp_c;
        fifo_model_en = 1'b1;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req_valid = 4'b0001;
            if (c == 7) begin
                n_tests++;
                if (fcount !== 5'd16 || ovf !== 1'b0 || n_writes != 1) begin
                    n_fail++;
                    $display("FAIL stall_fill count got %0d ovf %b writes %0d exp 16 0 1",
                             fcount, ovf, n_writes);
                end
                fifo_model_en = 1'b0;
            end
            #1;
            case (c)
                0:       exp_c = 8'h00;
                1, 7:    exp_c = 8'h1C;
                default: exp_c = 8'h04;
            endcase
            n_tests++;
            if (obs() !== exp_c) begin
                n_fail++;
                $display("FAIL stall_ctl c=%0d got %h exp %h", c, obs(), exp_c);
            end
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_reset_mid_burst();
        logic [7:0] exp_c[10] = '{8'h00, 8'h1C, 8'h1C, 8'h1C, 8'h1C,
                                  8'h00, 8'h2D, 8'h2D, 8'h00, 8'h1C};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = 4'hF;
            reset     = (c == 7);
            #1;
            n_tests++;
            if (obs() !== exp_c[c]) begin
                n_fail++;
                $display("FAIL midrst_ctl c=%0d got %h exp %h", c, obs(), exp_c[c]);
            end
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_fixed_priority();
        logic [7:0] exp_c;
        do_reset();
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            req_valid = 4'b1010;
            #1;
            if (c % 5 == 0) exp_c = (c == 0) ? 8'h00 : 8'h01;
            else            exp_c = 8'h2D;
            n_tests++;
            if (obs() !== exp_c) begin
                n_fail++;
                $display("FAIL fixed_ctl c=%0d got %h exp %h", c, obs(), exp_c);
            end
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    initial begin
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = dat(i);
        test_reset();
        test_stall();
`ifdef ARB_FIXED_PRIORITY_EN
        test_fixed_priority();
`else
        test_round_robin();
        test_drop();
        test_reset_mid_burst();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
